// File: rtl/mem_byte_ctrl_pkg.sv
// Shared types and constants for the byte-serial MEM-stage memory controller.
package mem_byte_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    // Index of the last byte of the access (n-1); unknown selects are word-sized.
    function automatic logic [1:0] last_idx(input logic [3:0] sel);
        if (sel == SEL_BYTE) return 2'd0;
        if (sel == SEL_HALF) return 2'd1;
        return 2'd3;
    endfunction

endpackage

// File: rtl/mem_byte_ctrl.sv
// Serialises a 32-bit MEM-stage access into byte transactions on a byte-wide
// synchronous RAM, stalling the pipeline until the access completes.
module mem_byte_ctrl
    import mem_byte_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    state_e            state_q;
    logic [1:0]        k_q;
    logic [1:0]        last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] ram_a_q;
    logic [7:0]        ram_dout_q;
    logic              ram_wr_q;

    logic [1:0]        k_next;
    logic [1:0]        k_prev;
    logic              unused_addr_hi;

    assign k_next = k_q + 2'd1;
    assign k_prev = k_q - 2'd1;
    assign unused_addr_hi = ^addr_i[31:ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q    <= ST_IDLE;
            k_q        <= '0;
            last_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ce_i) begin
                        we_q       <= we_i;
                        addr_q     <= addr_i[ADDR_W-1:0];
                        last_q     <= last_idx(sel_i);
                        wdata_q    <= wdata_i;
                        ram_a_q    <= addr_i[ADDR_W-1:0];
                        ram_dout_q <= wdata_i[7:0];
                        ram_wr_q   <= we_i;
                        k_q        <= '0;
                        if (!we_i) rdata_q <= '0;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Read data lags the address by one cycle, so lane k-1 lands now.
                    if (!we_q && k_q != 2'd0) rdata_q[{k_prev, 3'b000} +: 8] <= ram_din_i;
                    if (k_q != last_q) begin
                        ram_a_q    <= addr_q + {{(ADDR_W-2){1'b0}}, k_next};
                        ram_dout_q <= wdata_q[{k_next, 3'b000} +: 8];
                        k_q        <= k_next;
                    end else begin
                        ram_wr_q <= 1'b0;
                        state_q  <= we_q ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    rdata_q[{last_q, 3'b000} +: 8] <= ram_din_i;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_req_o = (state_q == ST_IDLE && ce_i) || (state_q == ST_XFER) || (state_q == ST_WAIT);
    assign rdata_o     = rdata_q;
    assign ram_a_o     = ram_a_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Scoreboard bench for mem_byte_ctrl: expected RAM writes and load words are
// queued at request time and retired as the DUT produces them.
module tb_mem_byte_ctrl;

    localparam int AW = 17;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [3:0]    sel_i;
    logic [31:0]   wdata_i;
    logic [31:0]   rdata_o;
    logic          stall_req_o;
    logic [AW-1:0] ram_a_o;
    logic [7:0]    ram_dout_o;
    logic          ram_wr_o;
    logic [7:0]    ram_din_i;

    logic [7:0]    ram [0:(1<<AW)-1];
    logic [7:0]    ref_mem [logic [AW-1:0]];
    wr_t           wr_q[$];
    logic [31:0]   rd_q[$];

    int checks   = 0;
    int failures = 0;

    mem_byte_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_req_o (stall_req_o),
        .ram_a_o     (ram_a_o),
        .ram_dout_o  (ram_dout_o),
        .ram_wr_o    (ram_wr_o),
        .ram_din_i   (ram_din_i)
    );

    always #5 clk = ~clk;

    // Byte-wide synchronous RAM: registered read, write on strobe.
    always @(posedge clk) begin
        if (ram_wr_o === 1'b1) ram[ram_a_o] <= ram_dout_o;
        ram_din_i <= ram[ram_a_o];
    end

    // Issue one access at cycle 0 (caller is just after a rising edge) and
    // follow it to its DONE cycle.
    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata, input logic keep_ce);
        int          n;
        int          stall_len;
        logic [31:0] exp;
        logic [AW-1:0] a;
        wr_t         w;
        n = (sel == 4'b0001) ? 1 : (sel == 4'b0011) ? 2 : 4;
        ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; wdata_i = wdata;
        exp = '0;
        for (int k = 0; k < n; k++) begin
            a = AW'(addr + 32'(k));
            if (we) begin
                w.a = a; w.d = wdata[8*k +: 8]; w.cyc = k + 1;
                wr_q.push_back(w);
                ref_mem[a] = w.d;
            end else begin
                exp[8*k +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
            end
        end
        if (!we) rd_q.push_back(exp);
        stall_len = we ? n + 1 : n + 2;
        for (int c = 0; c <= stall_len; c++) begin
            @(negedge clk);
            checks++;
            if (stall_req_o !== (c < stall_len)) begin
                failures++;
                $display("FAIL %s stall cycle %0d: got %b want %b", name, c, stall_req_o, c < stall_len);
            end
            if (ram_wr_o !== 1'b0) begin
                checks++;
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected write cycle %0d: wr=%b a=%h d=%h", name, c, ram_wr_o, ram_a_o, ram_dout_o);
                end else begin
                    w = wr_q.pop_front();
                    if (ram_a_o !== w.a || ram_dout_o !== w.d || c != w.cyc) begin
                        failures++;
                        $display("FAIL %s write: got %h@%h cyc %0d want %h@%h cyc %0d",
                                 name, ram_dout_o, ram_a_o, c, w.d, w.a, w.cyc);
                    end
                end
            end
            if (c == stall_len && !we) begin
                exp = rd_q.pop_front();
                checks++;
                if (rdata_o !== exp) begin
                    failures++;
                    $display("FAIL %s rdata at DONE: got %h want %h", name, rdata_o, exp);
                end
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                // Inputs must be ignored outside IDLE.
                we_i = ~we; addr_i = $urandom; wdata_i = $urandom; sel_i = 4'b0001;
                ce_i = keep_ce;
            end
        end
        checks++;
        if (wr_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing writes: got %0d pending want 0", name, wr_q.size());
        end
        wr_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; wdata_i = '0;
        #3;
        checks++;
        if (rdata_o !== 32'h0 || ram_a_o !== '0 || ram_dout_o !== 8'h0 || ram_wr_o !== 1'b0 || stall_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset outputs: got rd=%h a=%h d=%h wr=%b st=%b want all 0",
                     rdata_o, ram_a_o, ram_dout_o, ram_wr_o, stall_req_o);
        end
        ce_i = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b1) begin
            failures++;
            $display("FAIL reset stall follows ce: got %b want 1", stall_req_o);
        end
        ce_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        do_access("sw_100", 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_load_word();
        do_access("lw_100", 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    endtask

    task automatic test_load_partial();
        do_access("lb_103", 1'b0, 32'h0000_0103, 4'b0001, 32'h0, 1'b0);
        do_access("lh_102", 1'b0, 32'h0000_0102, 4'b0011, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        do_access("sh_wrap", 1'b1, 32'hABC1_FFFF, 4'b0011, 32'h5555_1234, 1'b0);
        do_access("lh_wrap", 1'b0, 32'h0001_FFFF, 4'b0011, 32'h0, 1'b0);
    endtask

    task automatic test_sel_other();
        do_access("sw_sel0100", 1'b1, 32'h0000_0200, 4'b0100, 32'h8765_4321, 1'b0);
        do_access("lw_sel0110", 1'b0, 32'h0000_0200, 4'b0110, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0400; sel_i = 4'b1111; wdata_i = 32'h1122_3344;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ram_wr_o !== 1'b1 || ram_a_o !== AW'(32'h400)) begin
            failures++;
            $display("FAIL rst_mid cycle1 write: got wr=%b a=%h want 1 @400", ram_wr_o, ram_a_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ram_wr_o !== 1'b0 || ram_a_o !== '0 || ram_dout_o !== 8'h0 || rdata_o !== 32'h0 || stall_req_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid async: got wr=%b a=%h d=%h rd=%h st=%b want 0 0 0 0 1",
                     ram_wr_o, ram_a_o, ram_dout_o, rdata_o, stall_req_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        do_access("sw_after_rst", 1'b1, 32'h0000_0400, 4'b1111, 32'hA55A_C33C, 1'b0);
        do_access("lw_after_rst", 1'b0, 32'h0000_0400, 4'b1111, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access("b2b_sb", 1'b1, 32'h0000_0300, 4'b0001, 32'hFFFF_FF55, 1'b1);
        do_access("b2b_lb", 1'b0, 32'h0000_0300, 4'b0001, 32'h0, 1'b1);
        do_access("b2b_sw", 1'b1, 32'h0000_0301, 4'b1111, 32'h0BAD_F00D, 1'b1);
        do_access("b2b_lw", 1'b0, 32'h0000_0300, 4'b1111, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_word();
        test_load_partial();
        test_wrap();
        test_sel_other();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
